// File: rtl/counter_bank_snap.sv
// Bank of independent accumulating counters with per-channel saturate/wrap limits,
// plus an atomic snapshot of all channels streamed out one channel per beat.
module counter_bank_snap #(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 4,
  parameter int CH_W     = ($clog2(CHANNELS) > 0) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       clear,
  input  logic [CHANNELS-1:0]       mode_wrap,
  input  logic [CHANNELS*WIDTH-1:0] increment,
  input  logic [CHANNELS*WIDTH-1:0] counter_max,
  output logic [CHANNELS*WIDTH-1:0] counter_out,
  output logic [CHANNELS-1:0]       at_max,
  output logic [CHANNELS-1:0]       tc_pulse,
  output logic [CHANNELS-1:0]       ovf_sticky,
  input  logic [CHANNELS-1:0]       ovf_clear,
  input  logic                      snap_req,
  output logic                      snap_busy,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [WIDTH-1:0]          m_data,
  output logic [CH_W-1:0]           m_chan,
  output logic                      m_last
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] r_cnt;
      logic             r_tc;
      logic             r_ovf;
      logic [WIDTH-1:0] w_inc;
      logic [WIDTH-1:0] w_max;
      logic [WIDTH:0]   w_sum;
      logic [WIDTH:0]   w_max_ext;
      logic [WIDTH:0]   w_rem;
      logic [WIDTH-1:0] w_next;
      logic             w_tc;
      logic             w_event;

      assign w_inc     = increment[gi*WIDTH +: WIDTH];
      assign w_max     = counter_max[gi*WIDTH +: WIDTH];
      assign w_max_ext = {1'b0, w_max};

      // Sum and wrap remainder are kept WIDTH+1 wide so an all-ones limit wraps modulo 2^WIDTH.
      always_comb begin
        w_sum  = {1'b0, r_cnt} + {1'b0, w_inc};
        w_rem  = w_sum - (w_max_ext + (WIDTH+1)'(1));
        w_next = w_sum[WIDTH-1:0];
        w_tc   = 1'b0;
        if (!mode_wrap[gi]) begin
          if (w_sum >= w_max_ext) begin
            w_next = w_max;
            w_tc   = (r_cnt != w_max);
          end
        end else if (w_sum > w_max_ext) begin
          w_tc   = 1'b1;
          w_next = (w_rem > w_max_ext) ? w_max : w_rem[WIDTH-1:0];
        end
      end

      assign w_event = en[gi] && !clear[gi] && w_tc;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= '0;
          r_tc  <= 1'b0;
          r_ovf <= 1'b0;
        end else begin
          if (clear[gi]) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
          end else if (!en[gi]) begin
            r_tc  <= 1'b0;
          end else begin
            r_cnt <= w_next;
            r_tc  <= w_tc;
          end
          // A new overflow beats a same-cycle clear request.
          if (w_event)
            r_ovf <= 1'b1;
          else if (ovf_clear[gi])
            r_ovf <= 1'b0;
        end
      end

      assign counter_out[gi*WIDTH +: WIDTH] = r_cnt;
      assign at_max[gi]     = (r_cnt == w_max);
      assign tc_pulse[gi]   = r_tc;
      assign ovf_sticky[gi] = r_ovf;
    end
  endgenerate

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_snap [CHANNELS];
  logic [CH_W-1:0]  r_chan;
  logic             r_valid;
  logic             r_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++)
        r_snap[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (snap_req) begin
            for (int i = 0; i < CHANNELS; i++)
              r_snap[i] <= counter_out[i*WIDTH +: WIDTH];
            r_state <= S_STREAM;
            r_chan  <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_STREAM: begin
          if (r_valid && m_ready) begin
            if (r_chan == LAST_CH) begin
              r_state <= S_IDLE;
              r_chan  <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_chan <= r_chan + CH_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_valid   = r_valid;
  assign snap_busy = r_busy;
  assign m_chan    = r_chan;
  assign m_data    = r_snap[r_chan];
  assign m_last    = r_valid && (r_chan == LAST_CH);

endmodule

// File: tb/tb_counter_bank_snap.sv
// Directed-vector bench for counter_bank_snap (8-bit counters, 4 channels).
module tb_counter_bank_snap;

  localparam int W = 8;
  localparam int C = 4;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [C-1:0]   en, clear, mode_wrap, ovf_clear;
  logic [C*W-1:0] increment, counter_max, counter_out;
  logic [C-1:0]   at_max, tc_pulse, ovf_sticky;
  logic           snap_req, snap_busy, m_valid, m_ready, m_last;
  logic [W-1:0]   m_data;
  logic [CW-1:0]  m_chan;

  int n_vec  = 0;
  int n_miss = 0;

  counter_bank_snap #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .mode_wrap(mode_wrap),
    .increment(increment), .counter_max(counter_max), .counter_out(counter_out),
    .at_max(at_max), .tc_pulse(tc_pulse), .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear),
    .snap_req(snap_req), .snap_busy(snap_busy), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_chan(m_chan), .m_last(m_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %-12s got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %-12s value %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic wrap, input logic [W-1:0] inc, input logic [W-1:0] mx);
    mode_wrap[i]         = wrap;
    increment[i*W +: W]  = inc;
    counter_max[i*W +: W] = mx;
  endtask

  function automatic logic [W-1:0] cnt(input int i);
    return counter_out[i*W +: W];
  endfunction

  int exp_w  [5] = '{3, 6, 9, 2, 5};
  int exp_tc [5] = '{0, 0, 0, 1, 0};

  initial begin
    reset = 1'b1; en = '0; clear = '0; mode_wrap = '0; ovf_clear = '0;
    increment = '0; counter_max = '0; snap_req = 1'b0; m_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_cnt",   counter_out, 0);
    check("rst_tc",    tc_pulse, 0);
    check("rst_ovf",   ovf_sticky, 0);
    check("rst_valid", m_valid, 0);
    check("rst_busy",  snap_busy, 0);
    check("rst_chan",  m_chan, 0);

    // saturating add must not lose the carry out of the top bit
    set_ch(0, 1'b0, 8'd250, 8'd255);
    en = 4'b0001;
    step();
    check("carry_250", cnt(0), 250);
    check("carry_tc0", tc_pulse[0], 0);
    increment[7:0] = 8'd10;
    step();
    check("carry_sat", cnt(0), 255);
    check("carry_tc1", tc_pulse[0], 1);
    check("carry_ovf", ovf_sticky[0], 1);
    step();
    check("hold_tc", tc_pulse[0], 0);
    check("hold_cnt", cnt(0), 255);
    check("hold_atmax", at_max[0], 1);
    en = '0;

    set_ch(1, 1'b1, 8'd3, 8'd9);
    en = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("wrap_cnt%0d", k), cnt(1), exp_w[k]);
      check($sformatf("wrap_tc%0d", k), tc_pulse[1], exp_tc[k]);
    end
    en = '0;
    check("wrap_ovf", ovf_sticky[1], 1);
    ovf_clear = 4'b0010;
    step();
    ovf_clear = '0;
    check("ovf_cleared", ovf_sticky[1], 0);

    set_ch(2, 1'b0, 8'd7, 8'd100);
    en = 4'b0100;
    step();
    check("prio_7", cnt(2), 7);
    clear = 4'b0100;
    step();
    clear = '0;
    check("prio_clr", cnt(2), 0);
    check("prio_tc", tc_pulse[2], 0);
    check("prio_ovf", ovf_sticky[2], 0);
    set_ch(2, 1'b1, 8'd3, 8'd4);
    step();
    check("setwin_3", cnt(2), 3);
    ovf_clear = 4'b0100;
    step();
    ovf_clear = '0;
    en = '0;
    check("setwin_cnt", cnt(2), 1);
    check("setwin_tc", tc_pulse[2], 1);
    check("setwin_ovf", ovf_sticky[2], 1);

    set_ch(3, 1'b1, 8'd200, 8'd255);
    en = 4'b1000;
    step();
    check("mod_200", cnt(3), 200);
    check("mod_tc0", tc_pulse[3], 0);
    step();
    check("mod_144", cnt(3), 144);
    check("mod_tc1", tc_pulse[3], 1);
    en = '0;

    clear = 4'b0001;
    step();
    clear = '0;
    set_ch(0, 1'b0, 8'd100, 8'd255);
    en = 4'b0001;
    step();
    check("low_100", cnt(0), 100);
    en = '0;
    counter_max[7:0] = 8'd50;
    #1;
    check("low_hold", cnt(0), 100);
    check("low_atmax0", at_max[0], 0);
    en = 4'b0001;
    step();
    check("low_50", cnt(0), 50);
    check("low_tc1", tc_pulse[0], 1);
    check("low_atmax1", at_max[0], 1);
    step();
    check("low_tc0", tc_pulse[0], 0);
    check("low_stay", cnt(0), 50);
    en = '0;

    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < C; i++)
      set_ch(i, 1'b0, 8'(10 * (i + 1)), 8'd255);
    en = 4'b1111;
    step();
    en = '0;
    check("snap_pre", counter_out, 32'h281E140A);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    en = 4'b1111;
    for (int h = 0; h < 3; h++) begin
      check($sformatf("stall_v%0d", h), m_valid, 1);
      check($sformatf("stall_ch%0d", h), m_chan, 0);
      check($sformatf("stall_d%0d", h), m_data, 10);
      step();
    end
    check("snap_busy", snap_busy, 1);
    m_ready = 1'b1;
    for (int k = 0; k < C; k++) begin
      check($sformatf("beat_ch%0d", k), m_chan, k);
      check($sformatf("beat_d%0d", k), m_data, 10 * (k + 1));
      check($sformatf("beat_last%0d", k), m_last, (k == C - 1) ? 1 : 0);
      snap_req = (k == 1);
      step();
    end
    snap_req = 1'b0;
    check("end_valid", m_valid, 0);
    check("end_busy", snap_busy, 0);

    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    check("abort_v", m_valid, 1);
    step(); step();
    check("abort_ch2", m_chan, 2);
    reset = 1'b1;
    step();
    check("abort_valid", m_valid, 0);
    check("abort_busy", snap_busy, 0);
    check("abort_cnt", counter_out, 0);
    check("abort_chan", m_chan, 0);
    check("abort_data", m_data, 0);
    reset = 1'b0;
    en = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
